snake_stream_ctrl: RTL

SNAKE_STREAM_CTRL -- requirements
Module: snake_stream_ctrl

---
 rtl/snake_stream_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/snake_stream_ctrl.sv
// ============================================================================
// Module      : snake_stream_ctrl
// Description : Arbitrates segment-RAM ownership between game logic and a
//               raster stream pass that reads the snake ring head-to-tail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_stream_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pass_start,
  input  logic [IDX_W:0]   len,
  input  logic [IDX_W-1:0] head_idx,
  input  logic             game_req,
  output logic             game_gnt,
  output logic             ram_ren,
  output logic [IDX_W-1:0] ram_raddr,
  input  logic [10:0]      ram_rdata,
  output logic [4:0]       snake_x,
  output logic [3:0]       snake_y,
  output logic [1:0]       snake_dir,
  output logic             snake_first,
  output logic             snake_last,
  output logic             snake_valid,
  output logic             busy,
  output logic             pass_done,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAME   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [IDX_W:0] MAX_LEN_W = (IDX_W+1)'(MAX_LEN);

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             drain_q, drain_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_first_q, rd_first_d;
  logic             rd_last_q, rd_last_d;
  logic             snake_valid_q, snake_valid_d;
  logic             snake_first_q, snake_first_d;
  logic             snake_last_q, snake_last_d;
  logic [10:0]      fields_q, fields_d;
  logic             pass_done_q, pass_done_d;
  logic             overrun_q, overrun_d;
  logic             consume;
  logic             issue_last;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    drain_d       = drain_q;
    rd_valid_d    = 1'b0;
    rd_first_d    = 1'b0;
    rd_last_d     = 1'b0;
    issue_last    = (cnt_q == (len_q - 1'b1));

    // A request arriving in IDLE is launched directly without waiting a cycle.
    consume   = (state_q == IDLE) && (pending_q || pass_start);
    overrun_d = pass_start && pending_q && !consume;
    pending_d = consume ? (pending_q && pass_start) : (pending_q || pass_start);

    case (state_q)
      IDLE: begin
        if (consume) begin
          state_d = STREAM;
          len_d   = (len > MAX_LEN_W) ? MAX_LEN_W : len;
          addr_d  = head_idx;
          cnt_d   = '0;
        end else if (game_req) begin
          state_d = GAME;
        end
      end
      GAME: begin
        if (!game_req) state_d = IDLE;
      end
      STREAM: begin
        if (len_q == '0) begin
          state_d = IDLE;
        end else begin
          rd_valid_d = 1'b1;
          rd_first_d = (cnt_q == '0);
          rd_last_d  = issue_last;
          addr_d     = addr_q - 1'b1;
          cnt_d      = cnt_q + 1'b1;
          drain_d    = 1'b0;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // RAM data lands one cycle after the read; register it into the beat.
    snake_valid_d = rd_valid_q;
    snake_first_d = rd_first_q;
    snake_last_d  = rd_last_q;
    fields_d      = rd_valid_q ? ram_rdata : fields_q;
    pass_done_d   = (snake_valid_q && snake_last_q) ||
                    ((state_q == STREAM) && (len_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      drain_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_first_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      snake_valid_q <= 1'b0;
      snake_first_q <= 1'b0;
      snake_last_q  <= 1'b0;
      fields_q      <= '0;
      pass_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      drain_q       <= drain_d;
      rd_valid_q    <= rd_valid_d;
      rd_first_q    <= rd_first_d;
      rd_last_q     <= rd_last_d;
      snake_valid_q <= snake_valid_d;
      snake_first_q <= snake_first_d;
      snake_last_q  <= snake_last_d;
      fields_q      <= fields_d;
      pass_done_q   <= pass_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign ram_ren     = (state_q == STREAM) && (len_q != '0);
  assign ram_raddr   = ram_ren ? addr_q : '0;
  assign game_gnt    = (state_q == GAME);
  assign busy        = (state_q != IDLE);
  assign snake_valid = snake_valid_q;
  assign snake_first = snake_first_q;
  assign snake_last  = snake_last_q;
  assign snake_x     = fields_q[4:0];
  assign snake_y     = fields_q[8:5];
  assign snake_dir   = fields_q[10:9];
  assign pass_done   = pass_done_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire
